// File: rtl/gif_capture_ctrl.sv
// GIF capture sequencer: writes NUM_FRAMES dithered camera frames into
// consecutive frame-store slots, then loops playback of those slots to the display.
module gif_capture_ctrl #(
    parameter int H_PIX      = 320,
    parameter int V_PIX      = 240,
    parameter int NUM_FRAMES = 8,
    parameter int ADDR_W     = 20,
    parameter int PLAY_DIV   = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [3:0]        skip_in,
    input  logic              pix_valid_in,
    input  logic [10:0]       pix_hcount_in,
    input  logic [9:0]        pix_vcount_in,
    input  logic              pix_in,
    input  logic              new_frame_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic              wr_data_out,
    output logic [ADDR_W-1:0] rd_base_out,
    output logic              play_valid_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [3:0]        cap_count_out
);

    localparam logic [ADDR_W-1:0] FRAME_SZ  = ADDR_W'(H_PIX * V_PIX);
    localparam logic [ADDR_W-1:0] ROW_SZ    = ADDR_W'(H_PIX);
    localparam int                DIV_W     = (PLAY_DIV > 1) ? $clog2(PLAY_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PLAY_DIV - 1);
    localparam logic [3:0]        SLOT_LAST = 4'(NUM_FRAMES - 1);
    localparam logic [4:0]        NUM_F5    = 5'(NUM_FRAMES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        SKIP    = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [3:0]         skip_latch_r, skip_cnt_r, cap_count_r, play_slot_r;
    logic [ADDR_W-1:0]  slot_base_r, wr_addr_r, rd_base_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic               have_gif_r, wr_en_r, wr_data_r, done_r;
    logic               in_range_s, sof_s, eof_s, start_s, last_slot_s, accept_s;
    logic [ADDR_W-1:0]  addr_s;

    assign in_range_s  = pix_valid_in && (pix_hcount_in < 11'(H_PIX)) && (pix_vcount_in < 10'(V_PIX));
    assign sof_s       = in_range_s && (pix_hcount_in == 11'd0) && (pix_vcount_in == 10'd0);
    assign eof_s       = in_range_s && (pix_hcount_in == 11'(H_PIX - 1)) && (pix_vcount_in == 10'(V_PIX - 1));
    assign start_s     = (state_r == IDLE) && start_in;
    assign last_slot_s = (({1'b0, cap_count_r} + 5'd1) == NUM_F5);
    assign addr_s      = slot_base_r + ADDR_W'(pix_vcount_in) * ROW_SZ + ADDR_W'(pix_hcount_in);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Next-state and pixel-accept decode
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_in) state_s = ARM;
                else          state_s = IDLE;
            end
            ARM: begin
                if (sof_s) begin
                    accept_s = 1'b1;
                    state_s  = CAPTURE;
                end else begin
                    state_s  = ARM;
                end
            end
            CAPTURE: begin
                accept_s = in_range_s;
                if (eof_s) begin
                    if (last_slot_s)                state_s = IDLE;
                    else if (skip_latch_r == 4'd0)  state_s = ARM;
                    else                            state_s = SKIP;
                end else begin
                    state_s = CAPTURE;
                end
            end
            SKIP: begin
                if (eof_s && ((skip_cnt_r + 4'd1) == skip_latch_r)) state_s = ARM;
                else                                                state_s = SKIP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Capture bookkeeping: slot base accumulator, slot and skip counters
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            skip_latch_r <= 4'd0;
            skip_cnt_r   <= 4'd0;
            cap_count_r  <= 4'd0;
            slot_base_r  <= '0;
        end else if (start_s) begin
            skip_latch_r <= skip_in;
            skip_cnt_r   <= 4'd0;
            cap_count_r  <= 4'd0;
            slot_base_r  <= '0;
        end else if ((state_r == CAPTURE) && eof_s) begin
            cap_count_r <= cap_count_r + 4'd1;
            if (!last_slot_s) begin
                slot_base_r <= slot_base_r + FRAME_SZ;
                skip_cnt_r  <= 4'd0;
            end
        end else if ((state_r == SKIP) && eof_s) begin
            skip_cnt_r <= skip_cnt_r + 4'd1;
        end
    end

    // Registered frame-store write port and completion pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            wr_en_r <= accept_s;
            done_r  <= (state_r == CAPTURE) && eof_s && last_slot_s;
            if (accept_s) begin
                wr_addr_r <= addr_s;
                wr_data_r <= pix_in;
            end
        end
    end

    // Playback scheduler; a fresh capture starts it at slot 0 with the divider cleared
    always_ff @(posedge clk_in) begin
        if (rst_in || start_s) begin
            have_gif_r  <= 1'b0;
            play_slot_r <= 4'd0;
            div_cnt_r   <= '0;
            rd_base_r   <= '0;
        end else if (done_r == 1'b0 && (state_r == CAPTURE) && eof_s && last_slot_s) begin
            have_gif_r  <= 1'b1;
            play_slot_r <= 4'd0;
            div_cnt_r   <= '0;
            rd_base_r   <= '0;
        end else if (have_gif_r && new_frame_in) begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= '0;
                if (play_slot_r == SLOT_LAST) begin
                    play_slot_r <= 4'd0;
                    rd_base_r   <= '0;
                end else begin
                    play_slot_r <= play_slot_r + 4'd1;
                    rd_base_r   <= rd_base_r + FRAME_SZ;
                end
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end
    end

    assign wr_en_out      = wr_en_r;
    assign wr_addr_out    = wr_addr_r;
    assign wr_data_out    = wr_data_r;
    assign rd_base_out    = rd_base_r;
    assign play_valid_out = have_gif_r;
    assign busy_out       = (state_r != IDLE);
    assign done_out       = done_r;
    assign cap_count_out  = cap_count_r;

endmodule
